fixed_point_addsub_acc: RTL and testbench

Parametrised successor to the fixed-point adder. It performs a two's-complement Q(WIDTH-FBITS-1).FBITS add or subtract under the same start/busy/done/valid/overflow handshake. It adds a selectable saturating output and an accumulate mode that chains results through an internal register. It sits in the DSP filter datapath as the reusable add/sub/accumulate primitive for MAC and integrator stages.

---
 rtl/fixed_point_pkg.sv | 25 ++
 rtl/fixed_point_addsub_acc_if.sv | 27 ++
 rtl/fixed_point_addsub_core.sv | 33 +++
 rtl/fixed_point_addsub_acc.sv | 110 +++++++++++
 tb/tb_fixed_point_addsub_acc.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Shared types and Q-format helpers for the fixed-point add/sub/accumulate block.
package fixed_point_pkg;

    localparam int unsigned Q_MAX_WIDTH     = 64;
    localparam int unsigned Q_MIN_WIDTH     = 4;
    localparam int unsigned Q_DEFAULT_WIDTH = 8;
    localparam int unsigned Q_DEFAULT_FBITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Most positive two's-complement value of the given width (0x7F..F).
    function automatic logic [Q_MAX_WIDTH-1:0] q_max(input int unsigned width);
        q_max = (Q_MAX_WIDTH'(1) << (width - 1)) - Q_MAX_WIDTH'(1);
    endfunction

    // Most negative two's-complement value of the given width (0x80..0).
    function automatic logic [Q_MAX_WIDTH-1:0] q_min(input int unsigned width);
        q_min = Q_MAX_WIDTH'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_point_addsub_acc_if.sv
// Request/response bundle between a controller and the add/sub/accumulate block.
interface fixed_point_addsub_acc_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_start;
    logic             i_sub;
    logic             i_acc;
    logic             i_clear;
    logic [WIDTH-1:0] i_operandA;
    logic [WIDTH-1:0] i_operandB;
    logic             o_busy;
    logic             o_done;
    logic             o_valid;
    logic             o_overflow;
    logic             o_acc_ovf;
    logic [WIDTH-1:0] o_val;

    modport master (
        output i_start, i_sub, i_acc, i_clear, i_operandA, i_operandB,
        input  o_busy, o_done, o_valid, o_overflow, o_acc_ovf, o_val
    );

    modport slave (
        input  i_start, i_sub, i_acc, i_clear, i_operandA, i_operandB,
        output o_busy, o_done, o_valid, o_overflow, o_acc_ovf, o_val
    );
endinterface

// File: rtl/fixed_point_addsub_core.sv
// Combinational two's-complement add/sub with overflow detect and optional clamp.
module fixed_point_addsub_core
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH    = Q_DEFAULT_WIDTH,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);
    localparam bit SAT_EN = (SATURATE != 0);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] sum;

    // One guard bit makes every case, including A - most-negative, exact.
    assign a_ext    = {op_a[WIDTH-1], op_a};
    assign b_ext    = {op_b[WIDTH-1], op_b};
    assign sum      = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    assign overflow = sum[WIDTH] ^ sum[WIDTH-1];

    always_comb begin
        result = sum[WIDTH-1:0];
        if (overflow && SAT_EN) begin
            result = sum[WIDTH] ? WIDTH'(q_min(WIDTH)) : WIDTH'(q_max(WIDTH));
        end
    end

endmodule

// File: rtl/fixed_point_addsub_acc.sv
// Add/sub/accumulate primitive: start/busy/done handshake, accumulator and sticky overflow.
module fixed_point_addsub_acc
    import fixed_point_pkg::*;
#(
    parameter int unsigned WIDTH    = Q_DEFAULT_WIDTH,
    parameter int unsigned FBITS    = Q_DEFAULT_FBITS,
    parameter int unsigned SATURATE = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    fixed_point_addsub_acc_if.slave        bus
);
    localparam bit SAT_EN = (SATURATE != 0);

    if (WIDTH < Q_MIN_WIDTH || WIDTH > Q_MAX_WIDTH || FBITS >= WIDTH) begin : g_param_check
        $error("fixed_point_addsub_acc: unsupported WIDTH/FBITS combination");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic             ovf_q, ovf_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] core_result;
    logic             core_ovf;

    fixed_point_addsub_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .op_a     (op_a_q),
        .op_b     (op_b_q),
        .sub      (sub_q),
        .result   (core_result),
        .overflow (core_ovf)
    );

    // Next-state and next-output logic; clear beats start in IDLE.
    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sub_d     = sub_q;
        val_d     = val_q;
        ovf_d     = ovf_q;
        acc_ovf_d = acc_ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.i_clear) begin
                    val_d     = '0;
                    acc_ovf_d = 1'b0;
                end else if (bus.i_start) begin
                    state_d = CALC;
                    op_a_d  = bus.i_acc ? val_q : bus.i_operandA;
                    op_b_d  = bus.i_operandB;
                    sub_d   = bus.i_sub;
                end
            end
            CALC: begin
                state_d   = DONE;
                val_d     = core_result;
                ovf_d     = core_ovf;
                acc_ovf_d = acc_ovf_q | core_ovf;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sub_q     <= 1'b0;
            val_q     <= '0;
            ovf_q     <= 1'b0;
            acc_ovf_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sub_q     <= sub_d;
            val_q     <= val_d;
            ovf_q     <= ovf_d;
            acc_ovf_q <= acc_ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_overflow = ovf_q;
    assign bus.o_acc_ovf  = acc_ovf_q;
    assign bus.o_val      = val_q;
    assign bus.o_valid    = done_q && (!ovf_q || SAT_EN);

endmodule

// File: tb/tb_fixed_point_addsub_acc.sv
// Drives a wrapping and a saturating instance in lockstep against an integer reference model.
module tb_fixed_point_addsub_acc;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 i_clk = ~i_clk;

    fixed_point_addsub_acc_if #(.WIDTH(8)) bus0 ();
    fixed_point_addsub_acc_if #(.WIDTH(8)) bus1 ();

    fixed_point_addsub_acc #(.WIDTH(8), .FBITS(4), .SATURATE(0)) dut0 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus0)
    );

    fixed_point_addsub_acc #(.WIDTH(8), .FBITS(4), .SATURATE(1)) dut1 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus1)
    );

    logic [7:0] val_w   [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       valid_w [2];
    logic       ovf_w   [2];
    logic       sticky_w[2];

    assign val_w[0]    = bus0.o_val;
    assign val_w[1]    = bus1.o_val;
    assign busy_w[0]   = bus0.o_busy;
    assign busy_w[1]   = bus1.o_busy;
    assign done_w[0]   = bus0.o_done;
    assign done_w[1]   = bus1.o_done;
    assign valid_w[0]  = bus0.o_valid;
    assign valid_w[1]  = bus1.o_valid;
    assign ovf_w[0]    = bus0.o_overflow;
    assign ovf_w[1]    = bus1.o_overflow;
    assign sticky_w[0] = bus0.o_acc_ovf;
    assign sticky_w[1] = bus1.o_acc_ovf;

    // Reference state: real-valued (integer) accumulator per instance.
    int m_val   [2];
    bit m_ovf   [2];
    bit m_sticky[2];

    task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[sat=%0d] observed=0x%0h expected=0x%0h", tag, k, obs, exp);
        end
    endtask

    function automatic int sx8(input logic [7:0] v);
        return (v >= 8'h80) ? int'(v) - 256 : int'(v);
    endfunction

    task automatic model_op(input int k, input bit sub, input bit acc, input logic [7:0] a, input logic [7:0] b);
        int opa;
        int r;
        bit ovf;
        opa = acc ? m_val[k] : sx8(a);
        r   = sub ? opa - sx8(b) : opa + sx8(b);
        ovf = (r > 127) || (r < -128);
        if (ovf && k == 1) r = (r > 0) ? 127 : -128;
        else               r = ((r + 128 + 512) % 256) - 128;
        m_val[k]    = r;
        m_ovf[k]    = ovf;
        m_sticky[k] = m_sticky[k] | ovf;
    endtask

    task automatic drive(input bit start, input bit sub, input bit acc, input bit clr,
                         input logic [7:0] a, input logic [7:0] b);
        bus0.i_start = start; bus1.i_start = start;
        bus0.i_sub   = sub;   bus1.i_sub   = sub;
        bus0.i_acc   = acc;   bus1.i_acc   = acc;
        bus0.i_clear = clr;   bus1.i_clear = clr;
        bus0.i_operandA = a;  bus1.i_operandA = a;
        bus0.i_operandB = b;  bus1.i_operandB = b;
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_busy"}, k, 8'(busy_w[k]), 8'h00);
            check({tag, "_done"}, k, 8'(done_w[k]), 8'h00);
            check({tag, "_val"},  k, val_w[k], 8'(m_val[k]));
            check({tag, "_sticky"}, k, 8'(sticky_w[k]), 8'(m_sticky[k]));
        end
    endtask

    // One operation; hold keeps start and clear high through the busy window.
    task automatic run_op(input string tag, input bit sub, input bit acc,
                          input logic [7:0] a, input logic [7:0] b, input bit hold);
        drive(1'b1, sub, acc, 1'b0, a, b);
        @(posedge i_clk); #1;
        if (hold) begin bus0.i_clear = 1'b1; bus1.i_clear = 1'b1; end
        else      begin bus0.i_start = 1'b0; bus1.i_start = 1'b0; end
        for (int k = 0; k < 2; k++) begin
            check({tag, "_calc_busy"}, k, 8'(busy_w[k]), 8'h01);
            check({tag, "_calc_done"}, k, 8'(done_w[k]), 8'h00);
        end
        @(posedge i_clk); #1;
        for (int k = 0; k < 2; k++) begin
            model_op(k, sub, acc, a, b);
            check({tag, "_done"},   k, 8'(done_w[k]),   8'h01);
            check({tag, "_busy"},   k, 8'(busy_w[k]),   8'h01);
            check({tag, "_val"},    k, val_w[k],        8'(m_val[k]));
            check({tag, "_ovf"},    k, 8'(ovf_w[k]),    8'(m_ovf[k]));
            check({tag, "_valid"},  k, 8'(valid_w[k]),  8'(!m_ovf[k] || k == 1));
            check({tag, "_sticky"}, k, 8'(sticky_w[k]), 8'(m_sticky[k]));
        end
        @(posedge i_clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        check_idle({tag, "_idle"});
        @(posedge i_clk); #1;
        check_idle({tag, "_after"});
    endtask

    task automatic do_clear(input bit with_start);
        drive(with_start, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22);
        @(posedge i_clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin m_val[k] = 0; m_sticky[k] = 1'b0; end
        check_idle("clear");
        @(posedge i_clk); #1;
        check_idle("clear_after");
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin m_val[k] = 0; m_ovf[k] = 1'b0; m_sticky[k] = 1'b0; end
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_val",   k, val_w[k], 8'h00);
            check("rst_busy",  k, 8'(busy_w[k]),   8'h00);
            check("rst_done",  k, 8'(done_w[k]),   8'h00);
            check("rst_valid", k, 8'(valid_w[k]),  8'h00);
            check("rst_ovf",   k, 8'(ovf_w[k]),    8'h00);
            check("rst_sticky",k, 8'(sticky_w[k]), 8'h00);
        end
        i_rst = 1'b0;

        // 1.5 + 2.25 = 3.75
        run_op("add", 1'b0, 1'b0, 8'h18, 8'h24, 1'b0);
        check("add_const", 0, val_w[0], 8'h3C);

        run_op("ovf_add", 1'b0, 1'b0, 8'h70, 8'h10, 1'b0);
        check("ovf_add_wrap", 0, val_w[0], 8'h80);
        check("ovf_add_sat",  1, val_w[1], 8'h7F);

        run_op("sub_neg", 1'b1, 1'b0, 8'h80, 8'h10, 1'b0);
        check("sub_wrap", 0, val_w[0], 8'h70);
        check("sub_sat",  1, val_w[1], 8'h80);

        run_op("sub_min", 1'b1, 1'b0, 8'h00, 8'h80, 1'b0);

        do_clear(1'b0);
        run_op("acc1", 1'b0, 1'b1, 8'h55, 8'h10, 1'b0);
        run_op("acc2", 1'b0, 1'b1, 8'h55, 8'h10, 1'b0);
        run_op("acc3", 1'b0, 1'b1, 8'h55, 8'h10, 1'b1);
        check("acc3_const", 0, val_w[0], 8'h30);
        check("acc3_const", 1, val_w[1], 8'h30);

        do_clear(1'b1);

        for (int i = 0; i < 40; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) do_clear(1'b0);
            else run_op("rand", 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), sel == 1);
        end

        // Reset during CALC aborts with no done pulse.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34);
        @(posedge i_clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        for (int k = 0; k < 2; k++) begin m_val[k] = 0; m_ovf[k] = 1'b0; m_sticky[k] = 1'b0; end
        for (int k = 0; k < 2; k++) begin
            check("abort_ovf",   k, 8'(ovf_w[k]),   8'h00);
            check("abort_valid", k, 8'(valid_w[k]), 8'h00);
        end
        check_idle("abort");
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check_idle("abort_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
